md5_block_builder: RTL and testbench

Generates the stream of padded 512-bit MD5 message blocks consumed by `md5_engine`. Each block holds the secret key followed by the ASCII decimal form of a running counter. The counter starts at 1 and advances by one per accepted block. The block runs until a downstream stop (hash hit) or until the counter overflows its digit budget.

---
 rtl/md5_block_builder.sv | 184 ++++++++++++++++++
 tb/tb_md5_block_builder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_block_builder.sv
// md5_block_builder: streams padded MD5 blocks of key || decimal(counter).
// Define MD5_BLOCK_BUILDER_STRIDE_EN to honour START_VALUE and STRIDE.
module md5_block_builder #(
    parameter int BLOCK_WIDTH   = 512,
    parameter int KEY_MAX_BYTES = 8,
    parameter int DIGITS_MAX    = 8
`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
    ,
    parameter int START_VALUE   = 1,
    parameter int STRIDE        = 1
`endif
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_valid,
    input  logic [KEY_MAX_BYTES*8-1:0]         key_data,
    input  logic [$clog2(KEY_MAX_BYTES+1)-1:0] key_length,
    input  logic                               stop,
    input  logic                               md5_block_ready,
    output logic                               md5_block_valid,
    output logic [BLOCK_WIDTH-1:0]             md5_block_data,
    output logic                               busy,
    output logic                               overflow
);
    localparam int KLW    = $clog2(KEY_MAX_BYTES+1);
    localparam int NW     = $clog2(DIGITS_MAX+1);
    localparam int NBYTES = BLOCK_WIDTH/8;
    localparam int PW     = $clog2(NBYTES);
    localparam int KW     = KEY_MAX_BYTES*8;
`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
    localparam int START  = START_VALUE;
    localparam int STEP   = STRIDE;
`else
    localparam int START  = 1;
    localparam int STEP   = 1;
`endif

    typedef logic [DIGITS_MAX-1:0][3:0] bcd_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic bcd_t to_bcd(input int v);
        bcd_t d;
        int   r;
        d = '0;
        r = v;
        for (int k = 0; k < DIGITS_MAX; k++) begin
            d[k] = 4'(r % 10);
            r    = r / 10;
        end
        return d;
    endfunction

    function automatic logic [NW-1:0] to_len(input int v);
        int r;
        int c;
        r = v;
        c = 1;
        for (int k = 1; k < DIGITS_MAX; k++) begin
            r = r / 10;
            if (r != 0) c = k + 1;
        end
        return NW'(c);
    endfunction

    localparam bcd_t          START_BCD = to_bcd(START);
    localparam logic [NW-1:0] START_N   = to_len(START);

    state_t          state_q, state_d;
    logic [KW-1:0]   key_q, key_d;
    logic [KLW-1:0]  klen_q, klen_d;
    bcd_t            dig_q, dig_d;
    logic [NW-1:0]   n_q, n_d;
    logic            ovf_q, ovf_d;

    bcd_t            inc_dig;
    logic [NW-1:0]   inc_n;
    logic            inc_ovf;
    logic            run;
    logic            xfer;

    logic [NBYTES-1:0][7:0] msg;
    logic [BLOCK_WIDTH-1:0] blk;

    assign run  = (state_q == RUN);
    assign xfer = run && md5_block_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            klen_q  <= '0;
            dig_q   <= START_BCD;
            n_q     <= START_N;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            klen_q  <= klen_d;
            dig_q   <= dig_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    // BCD ripple add; the used width grows when carry leaves the top digit
    always_comb begin
        logic [4:0] sum;
        logic [3:0] carry;
        inc_dig = dig_q;
        inc_n   = n_q;
        carry   = 4'(STEP);
        for (int k = 0; k < DIGITS_MAX; k++) begin
            sum = 5'(dig_q[k]) + 5'(carry);
            if (sum > 5'd9) begin
                inc_dig[k] = 4'(sum - 5'd10);
                carry      = 4'd1;
                if (k < DIGITS_MAX-1 && NW'(k+1) == n_q)
                    inc_n = n_q + 1'b1;
            end else begin
                inc_dig[k] = sum[3:0];
                carry      = 4'd0;
            end
        end
        inc_ovf = (carry != 4'd0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (key_valid) state_d = RUN;
            RUN: if (stop || (xfer && inc_ovf)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d  = key_q;
        klen_d = klen_q;
        dig_d  = dig_q;
        n_d    = n_q;
        ovf_d  = ovf_q;
        if (!run && key_valid) begin
            key_d  = key_data;
            klen_d = key_length;
            dig_d  = START_BCD;
            n_d    = START_N;
            ovf_d  = 1'b0;
        end else if (xfer) begin
            dig_d = inc_dig;
            n_d   = inc_n;
            if (inc_ovf) ovf_d = 1'b1;
        end
    end

    always_comb begin
        logic [PW-1:0] pos;
        logic [PW-1:0] len;
        logic [63:0]   bits;
        msg = '0;
        for (int p = 0; p < KEY_MAX_BYTES; p++)
            if (KLW'(p) < klen_q)
                msg[p] = key_q[KW-1-8*p -: 8];
        for (int k = 0; k < DIGITS_MAX; k++) begin
            pos = PW'(klen_q) + PW'(n_q) - PW'(1) - PW'(k);
            if (NW'(k) < n_q)
                msg[pos] = {4'h3, dig_q[k]};
        end
        len      = PW'(klen_q) + PW'(n_q);
        msg[len] = 8'h80;
        bits     = 64'(len) << 3;
        for (int i = 0; i < 8; i++)
            msg[NBYTES-8+i] = bits[8*i +: 8];
        for (int p = 0; p < NBYTES; p++)
            blk[BLOCK_WIDTH-1-8*p -: 8] = msg[p];
    end

    always_comb begin
        md5_block_valid = run;
        busy            = run;
        overflow        = ovf_q;
        md5_block_data  = run ? blk : '0;
    end

endmodule

// File: tb/tb_md5_block_builder.sv
// tb_md5_block_builder: table vectors, random ready, stop, reset and
// two-digit overflow checks against a string-based block model.
module tb_md5_block_builder;
    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid, stop, ready;
    logic [63:0]  key_data;
    logic [3:0]   key_length;
    logic         valid, busy, ovf;
    logic [511:0] data;

    logic         kv2, stop2, ready2;
    logic [63:0]  kd2;
    logic [3:0]   kl2;
    logic         valid2, busy2, ovf2;
    logic [511:0] data2;

    always #5 clk = ~clk;

    md5_block_builder dut (
        .clk(clk), .reset(reset), .key_valid(key_valid),
        .key_data(key_data), .key_length(key_length), .stop(stop),
        .md5_block_ready(ready), .md5_block_valid(valid),
        .md5_block_data(data), .busy(busy), .overflow(ovf)
    );

    md5_block_builder #(.DIGITS_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .key_valid(kv2),
        .key_data(kd2), .key_length(kl2), .stop(stop2),
        .md5_block_ready(ready2), .md5_block_valid(valid2),
        .md5_block_data(data2), .busy(busy2), .overflow(ovf2)
    );

`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
    logic         kv3, valid3, busy3, ovf3;
    logic [511:0] data3;
    md5_block_builder #(.START_VALUE(609043), .STRIDE(1)) dut3 (
        .clk(clk), .reset(reset), .key_valid(kv3),
        .key_data(key_data), .key_length(key_length), .stop(1'b0),
        .md5_block_ready(1'b1), .md5_block_valid(valid3),
        .md5_block_data(data3), .busy(busy3), .overflow(ovf3)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         num;
        int         pos80;
        logic [7:0] b56;
    } vec_t;
    vec_t tab [12];

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_key(input string k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < k.len(); i++) r[63-8*i -: 8] = k[i];
        return r;
    endfunction

    // Reference: key bytes, decimal text, 0x80, zeros, LE bit length.
    function automatic logic [511:0] model(input string k, input int num);
        logic [7:0]   m [64];
        logic [511:0] r;
        logic [63:0]  bits;
        string        s;
        int           p;
        s = $sformatf("%0d", num);
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        p = 0;
        for (int i = 0; i < k.len(); i++) begin m[p] = k[i]; p = p + 1; end
        for (int i = 0; i < s.len(); i++) begin m[p] = s[i]; p = p + 1; end
        m[p] = 8'h80;
        bits = 64'(p) * 64'd8;
        for (int i = 0; i < 8; i++) m[56+i] = bits[8*i +: 8];
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = m[i];
        return r;
    endfunction

    function automatic logic [7:0] byte_of(input logic [511:0] d, input int p);
        return d[511-8*p -: 8];
    endfunction

    initial begin
        int exp_num;
        int r;

        tab[0]  = '{1, 7, 8'h38};
        tab[1]  = '{2, 7, 8'h38};
        tab[2]  = '{3, 7, 8'h38};
        tab[3]  = '{4, 7, 8'h38};
        tab[4]  = '{5, 7, 8'h38};
        tab[5]  = '{6, 7, 8'h38};
        tab[6]  = '{7, 7, 8'h38};
        tab[7]  = '{8, 7, 8'h38};
        tab[8]  = '{9, 7, 8'h38};
        tab[9]  = '{10, 8, 8'h40};
        tab[10] = '{11, 8, 8'h40};
        tab[11] = '{12, 8, 8'h40};

        reset = 1'b1;
        key_valid = 1'b0; stop = 1'b0; ready = 1'b0;
        key_data = '0; key_length = '0;
        kv2 = 1'b0; stop2 = 1'b0; ready2 = 1'b0;
        kd2 = '0; kl2 = '0;
`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
        kv3 = 1'b0;
`endif

        #1;
        check("rst_valid", 512'(valid), 512'(0));
        check("rst_data", data, '0);
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_ovf", 512'(ovf), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_valid", 512'(valid), 512'(0));

        // table run, key "abcdef", ready held high
        key_data = pack_key("abcdef"); key_length = 4'd6;
        key_valid = 1'b1; ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            check($sformatf("tab%0d_valid", i), 512'(valid), 512'(1));
            check($sformatf("tab%0d_blk", i), data, model("abcdef", tab[i].num));
            check($sformatf("tab%0d_b56", i),
                  512'(byte_of(data, 56)), 512'(tab[i].b56));
            check($sformatf("tab%0d_80", i),
                  512'(byte_of(data, tab[i].pos80)), 512'(8'h80));
        end

        // random ready: no skip, no repeat, stable when stalled
        exp_num = 13;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check($sformatf("rnd%0d_valid", c), 512'(valid), 512'(1));
            check($sformatf("rnd%0d_blk", c), data, model("abcdef", exp_num));
            r = int'($urandom_range(0, 1));
            ready = (r == 1);
            if (r == 1) exp_num++;
        end
        check("rnd_ovf", 512'(ovf), 512'(0));

        // stop, reload, key_valid ignored in RUN, stop with transfer of 5
        @(negedge clk);
        stop = 1'b1; ready = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        check("stop_valid", 512'(valid), 512'(0));
        check("stop_busy", 512'(busy), 512'(0));
        check("stop_data", data, '0);
        key_valid = 1'b1;
        @(negedge clk);
        check("reload_blk", data, model("abcdef", 1));
        key_data = pack_key("zz"); key_length = 4'd2;
        @(negedge clk);
        key_valid = 1'b0;
        check("kv_in_run_ignored", data, model("abcdef", 1));
        ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("pre_stop%0d", k), data, model("abcdef", k));
            if (k == 5) stop = 1'b1;
        end
        @(negedge clk);
        stop = 1'b0; ready = 1'b0;
        check("stop5_valid", 512'(valid), 512'(0));
        check("stop5_busy", 512'(busy), 512'(0));
        key_data = pack_key("abcdef"); key_length = 4'd6;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("restart_blk", data, model("abcdef", 1));
        check("restart_busy", 512'(busy), 512'(1));

        // long run with 8-byte key across 9->10, 99->100, 999->1000
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        key_data = pack_key("zyxwvuts"); key_length = 4'd8;
        key_valid = 1'b1; ready = 1'b1;
        for (int num = 1; num <= 1005; num++) begin
            @(negedge clk);
            key_valid = 1'b0;
            check($sformatf("long%0d", num), data, model("zyxwvuts", num));
            if (num == 1005) ready = 1'b0;
        end

        // asynchronous reset while a block is stalled
        @(negedge clk);
        check("pre_rst_blk", data, model("zyxwvuts", 1005));
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 512'(valid), 512'(0));
        check("arst_data", data, '0);
        check("arst_busy", 512'(busy), 512'(0));
        check("arst_ovf", 512'(ovf), 512'(0));
        @(negedge clk);
        reset = 1'b0; ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d", c), 512'(valid), 512'(0));
        end
        key_data = pack_key("abcdef"); key_length = 4'd6;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("post_rst_blk", data, model("abcdef", 1));

        // two-digit builder overflows after 99
        kd2 = pack_key("ab"); kl2 = 4'd2; kv2 = 1'b1; ready2 = 1'b1;
        exp_num = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            kv2 = 1'b0;
            if (!valid2) break;
            check($sformatf("d2_%0d", exp_num), data2, model("ab", exp_num));
            exp_num++;
        end
        check("d2_count", 512'(exp_num - 1), 512'(99));
        check("d2_ovf", 512'(ovf2), 512'(1));
        check("d2_valid", 512'(valid2), 512'(0));
        check("d2_busy", 512'(busy2), 512'(0));
        check("d2_data", data2, '0);
        repeat (3) @(negedge clk);
        check("d2_ovf_sticky", 512'(ovf2), 512'(1));
        kv2 = 1'b1; ready2 = 1'b0;
        @(negedge clk);
        kv2 = 1'b0;
        check("d2_reload_ovf", 512'(ovf2), 512'(0));
        check("d2_reload_blk", data2, model("ab", 1));

`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
        key_data = pack_key("abcdef"); key_length = 4'd6;
        kv3 = 1'b1;
        @(negedge clk);
        kv3 = 1'b0;
        check("s_blk", data3, model("abcdef", 609043));
        check("s_b12", 512'(byte_of(data3, 12)), 512'(8'h80));
        check("s_b56", 512'(byte_of(data3, 56)), 512'(8'h60));
        @(negedge clk);
        check("s_next", data3, model("abcdef", 609044));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
